parking_gate_arbiter: RTL and testbench

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_pkg.sv | 19 +
 rtl/gate_timer.sv | 26 ++
 rtl/parking_gate_arbiter.sv | 125 ++++++++++++
 tb/tb_parking_gate_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter.
package parking_pkg;

  localparam int unsigned DEFAULT_CAPACITY = 8;
  localparam int unsigned OCC_W            = 4;
  localparam int unsigned TIMER_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable up-counter that saturates at limit and flags when it gets there.
module gate_timer
  import parking_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] limit,
  output logic               done_c
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count < limit) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign done_c = (count >= limit);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing one barrier between entry and exit lanes,
// tracking lot occupancy and flagging gates left open too long.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY     = DEFAULT_CAPACITY,
  parameter int unsigned OPEN_TIMEOUT = 15,
  parameter int unsigned CLOSE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_done,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             gate_open,
  output logic             busy,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             fault
);

  state_t             state, state_next;
  lane_t              lane, lane_next;
  lane_t              last_served, last_served_next;
  logic [OCC_W-1:0]   occ_next;
  logic               entry_grant_next, exit_grant_next, gate_open_next, fault_next;
  logic               entry_ok, exit_ok;
  logic               timer_load, timer_done;
  logic [TIMER_W-1:0] timer_limit;

  assign full  = (occupancy == OCC_W'(CAPACITY));
  assign empty = (occupancy == '0);
  assign busy  = (state != ST_IDLE);

  assign entry_ok = entry_req && !full;
  assign exit_ok  = exit_req && !empty;

  // One timer serves both the open timeout and the close hold.
  assign timer_limit = (state == ST_OPEN) ? TIMER_W'(OPEN_TIMEOUT - 1)
                                          : TIMER_W'(CLOSE_CYCLES - 1);

  gate_timer u_gate_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .limit  (timer_limit),
    .done_c (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      lane        <= LANE_ENTRY;
      last_served <= LANE_EXIT;
      occupancy   <= '0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      gate_open   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      lane        <= lane_next;
      last_served <= last_served_next;
      occupancy   <= occ_next;
      entry_grant <= entry_grant_next;
      exit_grant  <= exit_grant_next;
      gate_open   <= gate_open_next;
      fault       <= fault_next;
    end
  end

  always_comb begin
    state_next       = state;
    lane_next        = lane;
    last_served_next = last_served;
    occ_next         = occupancy;
    fault_next       = 1'b0;
    timer_load       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (entry_ok || exit_ok) begin
          state_next = ST_OPEN;
          timer_load = 1'b1;
          if (entry_ok && exit_ok) begin
            lane_next = (last_served == LANE_EXIT) ? LANE_ENTRY : LANE_EXIT;
          end else begin
            lane_next = entry_ok ? LANE_ENTRY : LANE_EXIT;
          end
        end
      end
      ST_OPEN: begin
        // A car clearing the sensor wins over a coincident timeout.
        if (pass_done) begin
          state_next       = ST_CLOSE;
          timer_load       = 1'b1;
          last_served_next = lane;
          occ_next = (lane == LANE_ENTRY) ? occupancy + OCC_W'(1)
                                          : occupancy - OCC_W'(1);
        end else if (timer_done) begin
          state_next       = ST_CLOSE;
          timer_load       = 1'b1;
          last_served_next = lane;
          fault_next       = 1'b1;
        end
      end
      ST_CLOSE: begin
        if (timer_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    gate_open_next   = (state_next == ST_OPEN);
    entry_grant_next = (state_next == ST_OPEN) && (lane_next == LANE_ENTRY);
    exit_grant_next  = (state_next == ST_OPEN) && (lane_next == LANE_EXIT);
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomised and directed bench for parking_gate_arbiter against a
// cycle-count reference model of the lot.
module tb_parking_gate_arbiter;

  localparam int unsigned CAP = 8;
  localparam int unsigned TO  = 15;
  localparam int unsigned CC  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_req, exit_req, pass_done;
  logic       entry_grant, exit_grant, gate_open, busy, full, empty, fault;
  logic [3:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0=none, 1=entry, 2=exit.
  int m_occ, m_last, m_owner, m_age, m_close_left, m_fault;

  always #5 clk = ~clk;

  parking_gate_arbiter #(
    .CAPACITY     (CAP),
    .OPEN_TIMEOUT (TO),
    .CLOSE_CYCLES (CC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .pass_done   (pass_done),
    .entry_grant (entry_grant),
    .exit_grant  (exit_grant),
    .gate_open   (gate_open),
    .busy        (busy),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .fault       (fault)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_last = 2; m_owner = 0; m_age = 0; m_close_left = 0; m_fault = 0;
  endtask

  task automatic model_edge(input logic er, input logic xr, input logic pd);
    bit e_ok, x_ok;
    m_fault = 0;
    if (m_owner != 0) begin
      if (pd || m_age == int'(TO) - 1) begin
        if (pd) m_occ += (m_owner == 1) ? 1 : -1;
        else    m_fault = 1;
        m_last       = m_owner;
        m_owner      = 0;
        m_close_left = CC;
      end else begin
        m_age++;
      end
    end else if (m_close_left > 0) begin
      m_close_left--;
    end else begin
      e_ok = er && (m_occ < int'(CAP));
      x_ok = xr && (m_occ > 0);
      if (e_ok && x_ok) m_owner = (m_last == 2) ? 1 : 2;
      else if (e_ok)    m_owner = 1;
      else if (x_ok)    m_owner = 2;
      m_age = 0;
    end
  endtask

  task automatic check_outputs();
    check("gate_open",   int'(gate_open),   int'(m_owner != 0));
    check("entry_grant", int'(entry_grant), int'(m_owner == 1));
    check("exit_grant",  int'(exit_grant),  int'(m_owner == 2));
    check("busy",        int'(busy),        int'(m_owner != 0 || m_close_left > 0));
    check("occupancy",   int'(occupancy),   m_occ);
    check("full",        int'(full),        int'(m_occ == int'(CAP)));
    check("empty",       int'(empty),       int'(m_occ == 0));
    check("fault",       int'(fault),       m_fault);
    check("grant_mutex", int'(entry_grant & exit_grant), 0);
  endtask

  // Drive at the falling edge, model the rising edge, check at the next fall.
  task automatic step(input logic er, input logic xr, input logic pd);
    entry_req = er; exit_req = xr; pass_done = pd;
    @(posedge clk);
    model_edge(er, xr, pd);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    entry_req = 0; exit_req = 0; pass_done = 0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // One full transaction: request, car passes in the first open cycle, close hold.
  task automatic txn(input logic er, input logic xr);
    step(er, xr, 1'b0);
    step(er, xr, 1'b1);
    repeat (CC) step(er, xr, 1'b0);
  endtask

  initial begin
    int opens, faults, occ_before;
    entry_req = 0; exit_req = 0; pass_done = 0; rst = 1'b1;

    apply_reset();
    check("reset_empty", int'(empty), 1);
    check("reset_occ",   int'(occupancy), 0);

    // Single entry: grant one cycle after sampling, pass on third cycle.
    step(1, 0, 0);
    check("s1_entry_grant", int'(entry_grant), 1);
    step(0, 0, 0);
    step(0, 0, 1);
    check("s1_occ", int'(occupancy), 1);
    step(0, 0, 0);
    check("s1_close_gate", int'(gate_open), 0);
    step(0, 0, 0);
    check("s1_idle", int'(busy), 0);

    // Reach occupancy 3 with last served = exit, then contend continuously.
    repeat (3) txn(1, 0);
    txn(0, 1);
    check("s2_start_occ", int'(occupancy), 3);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0);
      check("s2_alt_entry", int'(entry_grant), int'(k % 2 == 0));
      check("s2_alt_exit",  int'(exit_grant),  int'(k % 2 == 1));
      step(1, 1, 1);
      check("s2_occ", int'(occupancy), (k % 2 == 0) ? 4 : 3);
      repeat (CC) step(1, 1, 0);
    end

    // Fill the lot; contention then serves only the exit.
    repeat (5) txn(1, 0);
    check("s3_full", int'(full), 1);
    step(1, 1, 0);
    check("s3_no_entry", int'(entry_grant), 0);
    check("s3_exit",     int'(exit_grant), 1);
    step(1, 1, 1);
    check("s3_occ", int'(occupancy), 7);
    repeat (CC) step(0, 0, 0);

    // Open-gate timeout.
    occ_before = int'(occupancy);
    opens = 0; faults = 0;
    step(1, 0, 0);
    opens += int'(gate_open);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0);
      opens  += int'(gate_open);
      faults += int'(fault);
    end
    check("s4_open_cycles", opens, int'(TO));
    check("s4_fault_pulses", faults, 1);
    check("s4_occ", int'(occupancy), occ_before);
    check("s4_busy", int'(busy), 0);

    // Reset while the gate is open with five cars parked.
    apply_reset();
    repeat (5) txn(1, 0);
    check("s5_occ", int'(occupancy), 5);
    step(1, 0, 0);
    step(0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check("s5_gate",   int'(gate_open), 0);
    check("s5_grant",  int'(entry_grant | exit_grant), 0);
    check("s5_occ0",   int'(occupancy), 0);
    check("s5_empty",  int'(empty), 1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1);
    check("s5_pd_ignored", int'(occupancy), 0);

    // Random traffic.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
